// File: rtl/jpeg_arb_pkg.sv
// Shared definitions for the JPEG channel arbiter.
//
// Contents:
//   - channel codes CH_Y / CH_CB / CH_CR (the values driven on out_chan)
//   - scheduler state encoding S_Y / S_CB / S_CR
//   - FIFO entry layout {marker, last, data}. The bit positions are given as
//     offsets above the data MSB, so entry bit (DATA_W + MARK_BIT) is the marker.
//   - Y blocks per MCU: 1 by default, 4 when JPEG_ARB_MCU420_EN is defined
//
// Configuration macro: JPEG_ARB_MCU420_EN selects 4:2:0 block ordering.
package jpeg_arb_pkg;

    localparam logic [1:0] CH_Y  = 2'd0;
    localparam logic [1:0] CH_CB = 2'd1;
    localparam logic [1:0] CH_CR = 2'd2;

    // The encoding matches the channel codes, so a state maps directly to out_chan.
    typedef enum logic [1:0] {
        S_Y  = 2'd0,
        S_CB = 2'd1,
        S_CR = 2'd2
    } arb_state_e;

    // Offsets above the data field of a FIFO entry.
    localparam int unsigned LAST_BIT = 0;
    localparam int unsigned MARK_BIT = 1;

`ifdef JPEG_ARB_MCU420_EN
    localparam int unsigned Y_BLKS_PER_MCU = 4;
`else
    localparam int unsigned Y_BLKS_PER_MCU = 1;
`endif

    function automatic logic [1:0] chan_of(arb_state_e s);
        logic [1:0] ch;
        ch = CH_Y;
        unique case (s)
            S_Y:     ch = CH_Y;
            S_CB:    ch = CH_CB;
            S_CR:    ch = CH_CR;
            default: ch = CH_Y;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/jpeg_arb_fifo.sv
// Per-channel synchronous FIFO for the JPEG channel arbiter.
//
// The read data is the current head entry, shown combinationally. A push into
// a full FIFO is dropped and raises ovf_pulse for that one cycle. When the
// FIFO is full and a pop happens in the same cycle, the push is still
// accepted. clr flushes the FIFO on the next clock edge and takes priority
// over both push and pop.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   clr             synchronous flush
//   push, push_data write request and the entry to write
//   pop, pop_data   read request and the head entry
//   empty, full     occupancy flags
//   ovf_pulse       one-cycle pulse when a push was dropped
module jpeg_arb_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             ovf_pulse
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == OCC_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign ovf_pulse = push && !do_push && !clr;
    assign pop_data  = mem[rd_ptr_q];

    // The storage array has no reset. Its contents are only valid behind count_q.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + OCC_W'(1);
                2'b01:   count_q <= count_q - OCC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_chan_arbiter.sv
// JPEG channel arbiter. It merges the Huffman bitstream words from the Y, Cb
// and Cr pipelines into one ordered stream.
//
// Each channel writes into its own FIFO (jpeg_arb_fifo), because the
// upstream pipelines cannot be stalled. A scheduler drains the FIFOs in MCU
// order, taking one complete block per channel, and presents the words on a
// valid/ready output register.
//
// Configuration macro: JPEG_ARB_MCU420_EN. When it is defined, the scheduler
// serves four Y blocks per MCU (4:2:0). When it is undefined, it serves one Y
// block per MCU (4:4:4).
//
// Ports:
//   clk, rst                   clock and asynchronous active-low reset
//   clr                        synchronous soft clear
//   y_/cb_/cr_ data/valid/last per-channel input words and block-end tags
//   out_data/out_valid         merged output word, with out_ready as backpressure
//   out_chan                   source channel of out_data (0=Y, 1=Cb, 2=Cr)
//   out_last                   last word of an MCU
//   ovf                        sticky overflow flags {cr, cb, y}
//   mcu_count                  number of MCUs fully emitted (wraps)
module jpeg_chan_arbiter
    import jpeg_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] y_data,
    input  logic              y_valid,
    input  logic              y_last,
    input  logic [DATA_W-1:0] cb_data,
    input  logic              cb_valid,
    input  logic              cb_last,
    input  logic [DATA_W-1:0] cr_data,
    input  logic              cr_valid,
    input  logic              cr_last,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_chan,
    output logic              out_last,
    output logic [2:0]        ovf,
    output logic [CNT_W-1:0]  mcu_count
);

    localparam int unsigned ENTRY_W = DATA_W + 2;

    arb_state_e         state_q;
    logic [2:0]         push_vec;
    logic [2:0]         pop_vec;
    logic [2:0]         empty_vec;
    logic [2:0]         full_vec;
    logic [2:0]         ovf_pulse_vec;
    logic [ENTRY_W-1:0] push_entry [3];
    logic [ENTRY_W-1:0] head_entry [3];
    logic [ENTRY_W-1:0] head;
    logic               cur_empty;
    logic               pop_en;
    logic               head_mark;
    logic               head_last;
`ifdef JPEG_ARB_MCU420_EN
    logic [1:0]         yblk_q;
`endif

    // Build the FIFO entries from the inputs. valid=1 pushes a data word.
    // valid=0 with last=1 pushes a dataless marker with data zeroed.
    always_comb begin
        push_vec   = {cr_valid | cr_last, cb_valid | cb_last, y_valid | y_last};
        push_entry = '{default: '0};
        push_entry[0][DATA_W-1:0]       = y_valid ? y_data : '0;
        push_entry[0][DATA_W+LAST_BIT]  = y_last;
        push_entry[0][DATA_W+MARK_BIT]  = !y_valid;
        push_entry[1][DATA_W-1:0]       = cb_valid ? cb_data : '0;
        push_entry[1][DATA_W+LAST_BIT]  = cb_last;
        push_entry[1][DATA_W+MARK_BIT]  = !cb_valid;
        push_entry[2][DATA_W-1:0]       = cr_valid ? cr_data : '0;
        push_entry[2][DATA_W+LAST_BIT]  = cr_last;
        push_entry[2][DATA_W+MARK_BIT]  = !cr_valid;
    end

    for (genvar g = 0; g < 3; g++) begin : g_fifo
        jpeg_arb_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .push      (push_vec[g]),
            .push_data (push_entry[g]),
            .pop       (pop_vec[g]),
            .pop_data  (head_entry[g]),
            .empty     (empty_vec[g]),
            .full      (full_vec[g]),
            .ovf_pulse (ovf_pulse_vec[g])
        );
    end

    // Select the FIFO that the current state serves.
    always_comb begin
        head      = head_entry[0];
        cur_empty = empty_vec[0];
        pop_vec   = 3'b000;
        unique case (state_q)
            S_Y: begin
                head      = head_entry[0];
                cur_empty = empty_vec[0];
            end
            S_CB: begin
                head      = head_entry[1];
                cur_empty = empty_vec[1];
            end
            S_CR: begin
                head      = head_entry[2];
                cur_empty = empty_vec[2];
            end
            default: begin
                head      = head_entry[0];
                cur_empty = 1'b1;
            end
        endcase
        pop_en    = !cur_empty && (!out_valid || out_ready);
        head_mark = head[DATA_W+MARK_BIT];
        head_last = head[DATA_W+LAST_BIT];
        if (pop_en) begin
            pop_vec[chan_of(state_q)] = 1'b1;
        end
    end

    // Scheduler FSM, output register and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_Y;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_chan  <= CH_Y;
            out_last  <= 1'b0;
            ovf       <= 3'b000;
            mcu_count <= '0;
`ifdef JPEG_ARB_MCU420_EN
            yblk_q    <= 2'd0;
`endif
        end else if (clr) begin
            state_q   <= S_Y;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_chan  <= CH_Y;
            out_last  <= 1'b0;
            ovf       <= 3'b000;
            mcu_count <= '0;
`ifdef JPEG_ARB_MCU420_EN
            yblk_q    <= 2'd0;
`endif
        end else begin
            ovf <= ovf | ovf_pulse_vec;
            if (pop_en) begin
                if (head_mark) begin
                    // A marker produces no word. Any previous word was taken, so the register is free.
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= head[DATA_W-1:0];
                    out_chan  <= chan_of(state_q);
                    out_last  <= head_last && (state_q == S_CR);
                end
                if (head_last) begin
                    unique case (state_q)
                        S_Y: begin
`ifdef JPEG_ARB_MCU420_EN
                            if (yblk_q == 2'(Y_BLKS_PER_MCU - 1)) begin
                                yblk_q  <= 2'd0;
                                state_q <= S_CB;
                            end else begin
                                yblk_q  <= yblk_q + 2'd1;
                            end
`else
                            state_q <= S_CB;
`endif
                        end
                        S_CB: state_q <= S_CR;
                        S_CR: begin
                            state_q   <= S_Y;
                            mcu_count <= mcu_count + CNT_W'(1);
                        end
                        default: state_q <= S_Y;
                    endcase
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_chan_arbiter.sv
// Directed self-checking bench for jpeg_chan_arbiter.
// Inputs change 2 ns after each rising edge. Outputs are sampled at the
// falling edge, and accepted words are collected there into a queue.
`timescale 1ns/1ps
module tb_jpeg_chan_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned FD = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] y_data = '0, cb_data = '0, cr_data = '0;
    logic          y_valid = 1'b0, cb_valid = 1'b0, cr_valid = 1'b0;
    logic          y_last = 1'b0, cb_last = 1'b0, cr_last = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    out_chan;
    logic          out_last;
    logic [2:0]    ovf;
    logic [CW-1:0] mcu_count;

    int vectors = 0;
    int miscompares = 0;
    logic [34:0] obs_q[$];   // {chan, last, data}

    always #5 clk = ~clk;

    jpeg_chan_arbiter #(
        .DATA_W     (DW),
        .FIFO_DEPTH (FD),
        .CNT_W      (CW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_last    (y_last),
        .cb_data   (cb_data),
        .cb_valid  (cb_valid),
        .cb_last   (cb_last),
        .cr_data   (cr_data),
        .cr_valid  (cr_valid),
        .cr_last   (cr_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .ovf       (ovf),
        .mcu_count (mcu_count)
    );

    // A word presented with ready high at a falling edge is taken at the next rising edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            obs_q.push_back({out_chan, out_last, out_data});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int ch, input logic [DW-1:0] d, input logic v, input logic l);
        case (ch)
            0: begin y_data = d; y_valid = v; y_last = l; end
            1: begin cb_data = d; cb_valid = v; cb_last = l; end
            default: begin cr_data = d; cr_valid = v; cr_last = l; end
        endcase
        tick();
        y_valid = 1'b0; y_last = 1'b0;
        cb_valid = 1'b0; cb_last = 1'b0;
        cr_valid = 1'b0; cr_last = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        obs_q.delete();
    endtask

    task automatic wait_words(input string tag, input int n);
        for (int i = 0; i < 60 && obs_q.size() < n; i++) tick();
        repeat (3) tick();
        check(tag, 64'(obs_q.size()), 64'(n));
    endtask

    task automatic expect_word(input string tag, input logic [1:0] ch, input logic l,
                               input logic [DW-1:0] d);
        logic [34:0] w;
        w = '1;  // channel code 3 never matches an expected word
        if (obs_q.size() > 0) w = obs_q.pop_front();
        check(tag, 64'(w), 64'({ch, l, d}));
    endtask

    initial begin
        repeat (3) tick();
        check("rst_outputs", 64'({out_valid, out_last, out_chan, ovf, mcu_count, out_data}), 64'(0));
        rst = 1'b1;
        out_ready = 1'b1;
        tick();

`ifndef JPEG_ARB_MCU420_EN
        // Basic MCU: Y(3 words), Cb(1), Cr(1).
        send(0, 32'hA000_0000, 1'b1, 1'b0);
        check("t1_lat_empty", 64'(out_valid), 64'(0));
        send(0, 32'hA000_0001, 1'b1, 1'b0);
        check("t1_lat_first", 64'({out_valid, out_chan, out_data}), 64'({1'b1, 2'd0, 32'hA000_0000}));
        send(0, 32'hA000_0002, 1'b1, 1'b1);
        send(1, 32'hB000_0000, 1'b1, 1'b1);
        send(2, 32'hC000_0000, 1'b1, 1'b1);
        wait_words("t1_count", 5);
        expect_word("t1_w0", 2'd0, 1'b0, 32'hA000_0000);
        expect_word("t1_w1", 2'd0, 1'b0, 32'hA000_0001);
        expect_word("t1_w2", 2'd0, 1'b0, 32'hA000_0002);
        expect_word("t1_w3", 2'd1, 1'b0, 32'hB000_0000);
        expect_word("t1_w4", 2'd2, 1'b1, 32'hC000_0000);
        check("t1_mcu", 64'(mcu_count), 64'(1));

        // Cr arrives first and must wait for Y and Cb.
        do_clr();
        check("t2_clr_mcu", 64'({out_valid, mcu_count}), 64'(0));
        for (int i = 0; i < 5; i++) send(2, 32'hC100_0000 + 32'(i), 1'b1, 1'(i == 4));
        repeat (2) tick();
        check("t2_cr_held", 64'({out_valid, 8'(obs_q.size())}), 64'(0));
        send(0, 32'hA100_0000, 1'b1, 1'b0);
        send(0, 32'hA100_0001, 1'b1, 1'b1);
        send(1, 32'hB100_0000, 1'b1, 1'b1);
        wait_words("t2_count", 8);
        expect_word("t2_y0", 2'd0, 1'b0, 32'hA100_0000);
        expect_word("t2_y1", 2'd0, 1'b0, 32'hA100_0001);
        expect_word("t2_cb", 2'd1, 1'b0, 32'hB100_0000);
        for (int i = 0; i < 5; i++) expect_word("t2_cr", 2'd2, 1'(i == 4), 32'hC100_0000 + 32'(i));
        check("t2_mcu", 64'(mcu_count), 64'(1));

        // Backpressure: out_ready low while the Y block streams in and for 10 more cycles.
        do_clr();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 32'hD000_0000 + 32'(i), 1'b1, 1'(i == 3));
        for (int i = 0; i < 10; i++) begin
            check("t3_hold", 64'({out_valid, out_last, out_chan, out_data}),
                  64'({1'b1, 1'b0, 2'd0, 32'hD000_0000}));
            tick();
        end
        out_ready = 1'b1;
        send(1, 32'hE000_0000, 1'b1, 1'b1);
        send(2, 32'hF000_0000, 1'b1, 1'b1);
        wait_words("t3_count", 6);
        for (int i = 0; i < 4; i++) expect_word("t3_y", 2'd0, 1'b0, 32'hD000_0000 + 32'(i));
        expect_word("t3_cb", 2'd1, 1'b0, 32'hE000_0000);
        expect_word("t3_cr", 2'd2, 1'b1, 32'hF000_0000);
        check("t3_mcu", 64'(mcu_count), 64'(1));

        // Cb overflow while Y is being served, then an asynchronous reset mid-stream.
        do_clr();
        for (int i = 0; i < 16; i++) send(1, 32'hB200_0000 + 32'(i), 1'b1, 1'b0);
        check("t4_ovf_full", 64'(ovf), 64'(0));
        send(1, 32'hB200_0010, 1'b1, 1'b0);
        check("t4_ovf_set", 64'(ovf), 64'(3'b010));
        check("t4_no_cb_out", 64'(obs_q.size()), 64'(0));
        out_ready = 1'b0;
        send(0, 32'h6000_0000, 1'b1, 1'b0);
        tick();
        check("t4_pre_rst", 64'({out_valid, out_data}), 64'({1'b1, 32'h6000_0000}));
        rst = 1'b0;
        #1;
        check("t4_rst_async", 64'({out_valid, out_last, out_chan, ovf, mcu_count, out_data}), 64'(0));
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        send(0, 32'h6100_0000, 1'b1, 1'b1);
        send(1, 32'h6200_0000, 1'b1, 1'b1);
        send(2, 32'h6300_0000, 1'b1, 1'b1);
        wait_words("t4_count", 3);
        expect_word("t4_y", 2'd0, 1'b0, 32'h6100_0000);
        expect_word("t4_cb", 2'd1, 1'b0, 32'h6200_0000);
        expect_word("t4_cr", 2'd2, 1'b1, 32'h6300_0000);
        check("t4_ovf_after", 64'({ovf, mcu_count}), 64'({3'b000, 16'd1}));

        // Marker-only Cb block, then a marker-only Cr block.
        do_clr();
        send(0, 32'h7000_0000, 1'b1, 1'b1);
        send(1, 32'h0, 1'b0, 1'b1);
        send(2, 32'h7100_0000, 1'b1, 1'b1);
        wait_words("t5_count", 2);
        expect_word("t5_y", 2'd0, 1'b0, 32'h7000_0000);
        expect_word("t5_cr", 2'd2, 1'b1, 32'h7100_0000);
        check("t5_mcu", 64'(mcu_count), 64'(1));
        send(0, 32'h7200_0000, 1'b1, 1'b1);
        send(1, 32'h7300_0000, 1'b1, 1'b1);
        send(2, 32'h0, 1'b0, 1'b1);
        wait_words("t5b_count", 2);
        expect_word("t5b_y", 2'd0, 1'b0, 32'h7200_0000);
        expect_word("t5b_cb", 2'd1, 1'b0, 32'h7300_0000);
        check("t5b_mcu", 64'({out_valid, mcu_count}), 64'({1'b0, 16'd2}));
`else
        // 4:2:0 ordering: four Y blocks, then Cb, then Cr.
        for (int i = 0; i < 4; i++) send(0, 32'hA400_0000 + 32'(i), 1'b1, 1'b1);
        send(1, 32'hB400_0000, 1'b1, 1'b1);
        repeat (3) tick();
        check("t6_mcu_pre", 64'(mcu_count), 64'(0));
        send(2, 32'hC400_0000, 1'b1, 1'b1);
        wait_words("t6_count", 6);
        for (int i = 0; i < 4; i++) expect_word("t6_y", 2'd0, 1'b0, 32'hA400_0000 + 32'(i));
        expect_word("t6_cb", 2'd1, 1'b0, 32'hB400_0000);
        expect_word("t6_cr", 2'd2, 1'b1, 32'hC400_0000);
        check("t6_mcu", 64'(mcu_count), 64'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
